// File: rtl/lsu_sequencer_if.sv
// ---------------------------------------------------------------------------
// lsu_sequencer_if
//
// Request/acknowledge data-memory port between the MEM-stage load/store
// sequencer (master) and the data memory (slave).
//
// Signals:
//   mem_req_o    master->slave  request, held until acknowledged
//   mem_we_o     master->slave  1 = write, 0 = read
//   mem_addr_o   master->slave  word-aligned address
//   mem_be_o     master->slave  lane-shifted byte enables
//   mem_wdata_o  master->slave  lane-shifted store data
//   mem_ack_i    slave->master  completion; read data valid in the same cycle
//   mem_rdata_i  slave->master  read word
// ---------------------------------------------------------------------------
interface lsu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;

    // The sequencer drives the request side and consumes the response.
    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    // The memory consumes the request side and drives the response.
    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_sequencer.sv
// ---------------------------------------------------------------------------
// lsu_sequencer
//
// Multi-cycle load/store sequencer for the MEM stage. Accepts one decoded
// memory access per instruction, latches it, issues a byte-lane-aligned
// request on the req/ack memory port and holds it until acknowledged, stalls
// the pipeline while busy, and returns sign/zero-extended load data. Rejects
// misaligned halfword/word accesses and aborts requests that wait too long.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   valid_i              instruction in MEM is valid
//   mem_read_i/_write_i  load / store decoded (write wins if both)
//   mem_write_mask_i     unshifted store byte mask
//   funct3_i             access size and signedness
//   addr_i               effective address
//   store_data_i         rs2 value
//   mem                  memory port (lsu_sequencer_if.master)
//   stall_o              hold upstream pipeline
//   load_valid_o         one-cycle pulse, load_data_o valid
//   load_data_o          extended load result, held until the next load
//   misaligned_o         one-cycle pulse, access rejected
//   bus_err_o            one-cycle pulse, memory timeout
// ---------------------------------------------------------------------------
module lsu_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int XLEN           = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [3:0]      mem_write_mask_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    lsu_sequencer_if.master mem,
    output logic            stall_o,
    output logic            load_valid_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            misaligned_o,
    output logic            bus_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam int           CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]      r_state;
    logic [CW-1:0]   r_timer;
    logic [1:0]      r_addrLo;
    logic [2:0]      r_funct3;
    logic            r_we;
    logic            r_isLoad;
    logic            r_misaligned;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_wordAddr;
    logic [XLEN-1:0] r_loadData;

    logic            w_start;
    logic            w_misaligned;
    logic            w_emptyStore;
    logic [3:0]      w_beShift;
    logic [XLEN-1:0] w_wdataShift;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_loadExt;

    // Decode of the incoming access. Alignment is judged from the size field
    // funct3[1:0] so it applies identically to loads and stores.
    assign w_start      = valid_i & (mem_read_i | mem_write_i);
    assign w_misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                          ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    assign w_emptyStore = mem_write_i & (mem_write_mask_i == 4'b0000);
    assign w_beShift    = mem_write_mask_i << addr_i[1:0];
    assign w_wdataShift = store_data_i << {addr_i[1:0], 3'b000};

    // The addressed byte is moved down to lane 0 before extension.
    assign w_lane = mem.mem_rdata_i >> {r_addrLo, 3'b000};

    // Load result extension; unsupported encodings yield zero.
    always_comb begin
        w_loadExt = '0;
        case (r_funct3)
            3'b000:  w_loadExt = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_loadExt = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_loadExt = w_lane;
            3'b100:  w_loadExt = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            3'b101:  w_loadExt = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            default: w_loadExt = '0;
        endcase
    end

    // Main sequencer. IDLE latches the access; rejected or empty accesses go
    // straight to DONE so the pipeline still sees a one-cycle turnaround.
    // REQ waits for ack, bounded by the timeout counter; ack in the final
    // allowed cycle still completes normally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_addrLo     <= '0;
            r_funct3     <= '0;
            r_we         <= 1'b0;
            r_isLoad     <= 1'b0;
            r_misaligned <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_wordAddr   <= '0;
            r_loadData   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addrLo     <= addr_i[1:0];
                        r_funct3     <= funct3_i;
                        r_we         <= mem_write_i;
                        r_isLoad     <= ~mem_write_i;
                        r_misaligned <= w_misaligned;
                        r_be         <= mem_write_i ? w_beShift : 4'b1111;
                        r_wdata      <= mem_write_i ? w_wdataShift : '0;
                        r_wordAddr   <= {addr_i[XLEN-1:2], 2'b00};
                        r_timer      <= '0;
                        if (w_misaligned || w_emptyStore) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack_i) begin
                        r_state <= S_DONE;
                        r_timer <= '0;
                        if (r_isLoad) begin
                            r_loadData <= w_loadExt;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_state <= S_ERR;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory port is driven straight from the latched access so it stays
    // stable for the whole request including the ack cycle.
    assign mem.mem_req_o   = (r_state == S_REQ);
    assign mem.mem_we_o    = r_we;
    assign mem.mem_addr_o  = r_wordAddr;
    assign mem.mem_be_o    = r_be;
    assign mem.mem_wdata_o = r_wdata;

    // Stall covers the start cycle combinationally plus all of REQ; it is
    // forced low while reset is held so the pipeline is released at once.
    assign stall_o      = ~rst_i & (((r_state == S_IDLE) & w_start) | (r_state == S_REQ));
    assign load_valid_o = (r_state == S_DONE) & r_isLoad & ~r_misaligned;
    assign misaligned_o = (r_state == S_DONE) & r_misaligned;
    assign bus_err_o    = (r_state == S_ERR);
    assign load_data_o  = r_loadData;

endmodule
